// File: rtl/audio_mix_scheduler.sv
// Mixes NUM_CH stereo PCM sources into one saturated {R,L} word per frame and
// hands it to audio_output through a toggle/full write port with holdoff pacing.
module audio_mix_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 255,
  parameter int HOLDOFF = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH*32-1:0]  src_data,
  input  logic [NUM_CH-1:0]     src_valid,
  output logic [NUM_CH-1:0]     src_ready,
  input  logic [NUM_CH-1:0]     ch_enable,
  output logic [31:0]           out_data,
  output logic                  out_valid_toggle,
  input  logic                  out_full,
  output logic [15:0]           underrun_count,
  output logic [15:0]           frame_count
);

  localparam int AW = 16 + $clog2(NUM_CH);
  localparam int CW = $clog2(NUM_CH);
  localparam int HW = $clog2(HOLDOFF + 1);

  localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

  typedef enum logic [1:0] {IDLE, GATHER, SAT, PUSH} state_t;

  state_t                 state_q, state_d;
  logic [NUM_CH-1:0]      en_lat_q, en_lat_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [15:0]            wait_q, wait_d;
  logic signed [AW-1:0]   acc_l_q, acc_l_d;
  logic signed [AW-1:0]   acc_r_q, acc_r_d;
  logic [HW-1:0]          holdoff_q, holdoff_d;
  logic [31:0]            out_data_q, out_data_d;
  logic                   tog_q, tog_d;
  logic [15:0]            underrun_q, underrun_d;
  logic [15:0]            frame_q, frame_d;
  logic                   adv;

  logic [31:0]            samp_a [NUM_CH];
  logic [31:0]            samp;
  logic signed [AW-1:0]   samp_l, samp_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_split
    assign samp_a[g] = src_data[32*g +: 32];
  end

  assign samp   = samp_a[ch_q];
  assign samp_l = AW'($signed(samp[15:0]));
  assign samp_r = AW'($signed(samp[31:16]));

  function automatic logic [15:0] sat16(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return 16'h7FFF;
    else if (v < SAT_MIN) return 16'h8000;
    else                  return v[15:0];
  endfunction

  // State and control registers; reset discards any in-flight frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      en_lat_q   <= '0;
      ch_q       <= '0;
      wait_q     <= '0;
      holdoff_q  <= '0;
      out_data_q <= '0;
      tog_q      <= 1'b0;
      underrun_q <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      en_lat_q   <= en_lat_d;
      ch_q       <= ch_d;
      wait_q     <= wait_d;
      holdoff_q  <= holdoff_d;
      out_data_q <= out_data_d;
      tog_q      <= tog_d;
      underrun_q <= underrun_d;
      frame_q    <= frame_d;
    end
  end

  // Accumulators need no reset: IDLE clears them before every frame.
  always_ff @(posedge clk) begin
    acc_l_q <= acc_l_d;
    acc_r_q <= acc_r_d;
  end

  always_comb begin
    state_d    = state_q;
    en_lat_d   = en_lat_q;
    ch_d       = ch_q;
    wait_d     = wait_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    out_data_d = out_data_q;
    tog_d      = tog_q;
    underrun_d = underrun_q;
    frame_d    = frame_q;
    holdoff_d  = (holdoff_q != '0) ? holdoff_q - 1'b1 : '0;
    adv        = 1'b0;

    case (state_q)
      IDLE: begin
        en_lat_d = ch_enable;
        acc_l_d  = '0;
        acc_r_d  = '0;
        ch_d     = '0;
        wait_d   = '0;
        state_d  = GATHER;
      end
      GATHER: begin
        if (!en_lat_q[ch_q]) begin
          adv = 1'b1;
        end else if (src_valid[ch_q]) begin
          acc_l_d = acc_l_q + samp_l;
          acc_r_d = acc_r_q + samp_r;
          adv     = 1'b1;
        end else if (wait_q == 16'(TIMEOUT - 1)) begin
          if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
          adv = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
        if (adv) begin
          wait_d = '0;
          if (ch_q == CW'(NUM_CH - 1)) state_d = SAT;
          else                         ch_d    = ch_q + 1'b1;
        end
      end
      SAT: begin
        out_data_d = {sat16(acc_r_q), sat16(acc_l_q)};
        state_d    = PUSH;
      end
      PUSH: begin
        // full lags the toggle capture, so it is only trusted once holdoff expires.
        if (holdoff_q == '0 && !out_full) begin
          tog_d     = ~tog_q;
          frame_d   = frame_q + 16'd1;
          holdoff_d = HW'(HOLDOFF);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    if (state_q == GATHER && en_lat_q[ch_q]) src_ready[ch_q] = 1'b1;
  end

  assign out_data         = out_data_q;
  assign out_valid_toggle = tog_q;
  assign underrun_count   = underrun_q;
  assign frame_count      = frame_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Directed bench for audio_mix_scheduler: mixing, saturation, enables,
// source timeout, full back-pressure and mid-frame reset.
module tb_audio_mix_scheduler;

  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 8;
  localparam int HOLDOFF = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH*32-1:0] src_data;
  logic [NUM_CH-1:0]    src_valid;
  logic [NUM_CH-1:0]    src_ready;
  logic [NUM_CH-1:0]    ch_enable;
  logic [31:0]          out_data;
  logic                 out_valid_toggle;
  logic                 out_full;
  logic [15:0]          underrun_count;
  logic [15:0]          frame_count;

  int n_checks  = 0;
  int n_errors  = 0;
  int multi_hot = 0;
  logic [NUM_CH-1:0] ready_seen = '0;

  always #5 clk = ~clk;

  audio_mix_scheduler #(
    .NUM_CH (NUM_CH),
    .TIMEOUT(TIMEOUT),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .src_data        (src_data),
    .src_valid       (src_valid),
    .src_ready       (src_ready),
    .ch_enable       (ch_enable),
    .out_data        (out_data),
    .out_valid_toggle(out_valid_toggle),
    .out_full        (out_full),
    .underrun_count  (underrun_count),
    .frame_count     (frame_count)
  );

  always @(negedge clk) begin
    ready_seen |= src_ready;
    if ($countones(src_ready) > 1) multi_hot++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [15:0] l, input logic [15:0] r);
    src_data[32*i +: 32] = {r, l};
  endtask

  task automatic wait_frame(input logic [15:0] target, output int cyc);
    cyc = 0;
    while (frame_count !== target && cyc < 400) begin
      tick();
      cyc++;
    end
    check($sformatf("frame_%0d", target), {16'h0, frame_count}, {16'h0, target});
  endtask

  initial begin
    int cyc;
    src_data  = '0;
    src_valid = '0;
    ch_enable = '0;
    out_full  = 1'b0;
    reset     = 1'b1;
    repeat (3) tick();

    check("rst_out_data", out_data, 32'h0);
    check("rst_toggle", {31'h0, out_valid_toggle}, 32'h0);
    check("rst_underrun", {16'h0, underrun_count}, 32'h0);
    check("rst_frames", {16'h0, frame_count}, 32'h0);
    check("rst_ready", {28'h0, src_ready}, 32'h0);

    // Basic mix: L = 100+200-50+7 = 257, R = 0
    set_src(0, 16'd100, 16'd0);
    set_src(1, 16'd200, 16'd0);
    set_src(2, 16'hFFCE, 16'd0);
    set_src(3, 16'd7, 16'd0);
    src_valid = 4'hF;
    ch_enable = 4'hF;
    reset     = 1'b0;
    wait_frame(16'd1, cyc);
    check("mix_basic", out_data, 32'h0000_0101);
    check("mix_toggle", {31'h0, out_valid_toggle}, 32'h1);
    check("mix_underrun", {16'h0, underrun_count}, 32'h0);
    wait_frame(16'd2, cyc);
    check("period_all_valid", cyc, 32'd7);

    // Positive and negative saturation
    for (int i = 0; i < NUM_CH; i++) set_src(i, 16'h7000, 16'h7000);
    wait_frame(16'd3, cyc);
    check("sat_pos", out_data, 32'h7FFF_7FFF);
    for (int i = 0; i < NUM_CH; i++) set_src(i, 16'h9000, 16'h9000);
    wait_frame(16'd4, cyc);
    check("sat_neg", out_data, 32'h8000_8000);

    // Partial enable: L = 1000-300 = 700, R = -2+10 = 8
    set_src(0, 16'd1000, 16'hFFFE);
    set_src(1, 16'd5000, 16'd5000);
    set_src(2, 16'hFED4, 16'd10);
    set_src(3, 16'd7, 16'd7);
    ch_enable  = 4'b0101;
    ready_seen = '0;
    wait_frame(16'd5, cyc);
    check("mix_enable_0101", out_data, 32'h0008_02BC);
    check("ready_seen_0101", {28'h0, ready_seen}, 32'h5);

    // Timeout on ch2: L = 1+1+1 = 3, R = 2+2+2 = 6
    reset = 1'b1;
    tick();
    tick();
    ch_enable = 4'hF;
    for (int i = 0; i < NUM_CH; i++) set_src(i, 16'd1, 16'd2);
    set_src(2, 16'd1000, 16'd2);
    src_valid = 4'b1011;
    reset     = 1'b0;
    wait_frame(16'd1, cyc);
    check("timeout_mix", out_data, 32'h0006_0003);
    check("timeout_underrun1", {16'h0, underrun_count}, 32'd1);
    wait_frame(16'd2, cyc);
    check("period_timeout", cyc, 32'd14);
    check("timeout_underrun2", {16'h0, underrun_count}, 32'd2);

    // Back-pressure: L = 1+1+1000+1 = 1003, R = 8; stalls in PUSH
    src_valid = 4'hF;
    out_full  = 1'b1;
    repeat (50) tick();
    check("full_no_push", {16'h0, frame_count}, 32'd2);
    check("full_toggle_held", {31'h0, out_valid_toggle}, 32'h0);
    check("full_ready_low", {28'h0, src_ready}, 32'h0);
    check("full_data", out_data, 32'h0008_03EB);
    check("full_underrun", {16'h0, underrun_count}, 32'd2);
    out_full = 1'b0;
    tick();
    check("full_release_push", {16'h0, frame_count}, 32'd3);
    check("full_release_toggle", {31'h0, out_valid_toggle}, 32'h1);
    tick();
    check("full_single_push", {16'h0, frame_count}, 32'd3);

    // Reset while gathering ch2, then a clean frame: L = 40, R = -40
    cyc = 0;
    while (src_ready !== 4'b0100 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("reach_ch2", {28'h0, src_ready}, 32'h4);
    reset = 1'b1;
    for (int i = 0; i < NUM_CH; i++) set_src(i, 16'd10, 16'hFFF6);
    tick();
    check("midrst_frames", {16'h0, frame_count}, 32'h0);
    check("midrst_underrun", {16'h0, underrun_count}, 32'h0);
    check("midrst_toggle", {31'h0, out_valid_toggle}, 32'h0);
    check("midrst_data", out_data, 32'h0);
    check("midrst_ready", {28'h0, src_ready}, 32'h0);
    reset = 1'b0;
    wait_frame(16'd1, cyc);
    check("post_rst_mix", out_data, 32'hFFD8_0028);
    check("post_rst_underrun", {16'h0, underrun_count}, 32'h0);

    check("ready_onehot", multi_hot, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
